multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Main sequencing FSM of the 16-bit multicycle RISC core. Walks each
//  instruction through FETCH/DECODE/EXEC/MEM/WB and drives the ALU
//  (alu_op: AND/ADD/SUB), PC, IR, memory and register-file enables.
//  Consumes ALU zero/negative flags for branches; stalls on memory handshake.
// PARAMETERS
//  OPC_W      4    opcode field width (instr[15:12])
//  ALUOP_W    3    ALU control width; AND=3'b000 ADD=3'b001 SUB=3'b010
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   synchronous, active-high
//  opcode      in   4   IR[15:12], valid from DECODE onward
//  zero        in   1   ALU zero flag (combinational, same cycle)
//  negative    in   1   ALU negative flag
//  mem_ready   in   1   memory done; qualifies every mem_read/mem_write cycle
//  pc_write    out  1   PC load enable
//  pc_src      out  2   0=ALU result(PC+1) 1=branch target reg 2=jump imm
//  ir_write    out  1   IR load enable
//  mem_read    out  1   memory read request
//  mem_write   out  1   memory write request
//  addr_src    out  1   0=PC 1=ALU-out register
//  alu_op      out  3   ALU operation select
//  alu_src_a   out  1   0=PC 1=reg A
//  alu_src_b   out  2   0=reg B 1=const 1 2=sign-ext imm
//  reg_write   out  1   register-file write enable
//  wb_src      out  1   0=ALU-out 1=MDR
//  illegal     out  1   sticky: undefined opcode decoded
//  state_o     out  3   current state, for debug/bench
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 (encoded in package).
//  Reset: state=FETCH, illegal=0; all outputs combinational from state and
//   opcode (Moore except pc_write in EXEC on branch); idle value all 0.
//  FETCH: mem_read=1 addr_src=0 alu_src_a=0 alu_src_b=1 alu_op=ADD.
//   Stay while !mem_ready; when mem_ready: ir_write=1 pc_write=1 pc_src=0,
//   -> DECODE. No IR/PC write in a stalled cycle.
//  DECODE: alu_src_a=0 alu_src_b=2 alu_op=ADD (branch target precompute).
//   -> EXEC, except undefined opcode -> HALT with illegal set next cycle.
//  Opcodes: 0 AND,1 ADD,2 SUB (R-type); 3 ADDI; 4 LW; 5 SW; 6 BEQ; 7 BNE;
//   8 JMP; 15 HALT; 9..14 undefined.
//  EXEC: R-type alu_src_a=1 alu_src_b=0 alu_op per opcode -> WB.
//   ADDI/LW/SW: alu_src_a=1 alu_src_b=2 ADD; ADDI->WB, LW/SW->MEM.
//   BEQ/BNE: alu_src_a=1 alu_src_b=0 SUB; pc_write=zero (BEQ) or !zero
//   (BNE), pc_src=1 -> FETCH. JMP: pc_write=1 pc_src=2 -> FETCH.
//   HALT opcode -> HALT.
//  MEM: addr_src=1; LW mem_read=1, SW mem_write=1; hold until mem_ready;
//   LW->WB, SW->FETCH. Request stays asserted and stable while stalled.
//  WB: reg_write=1 exactly one cycle; wb_src=1 for LW else 0 -> FETCH.
//  HALT: all enables 0; leaves only on reset.
//  Latency (mem_ready=1 always): R/ADDI 4 cyc, LW 5, SW 4, BEQ/BNE/JMP 3.
//  reset mid-instruction: next cycle state=FETCH, no write enables asserted
//   in the reset cycle (reset overrides all outputs to 0).
//  negative is latched into a 1-bit reg in EXEC for future BLT; no effect now.
// STRUCTURE
//  Package mc_ctrl_pkg: state enum, opcode constants, ALU_AND/ADD/SUB codes,
//   pc_src/alu_src_b encodings (shared with datapath and ALU).
//  One sub-module: mc_decode (combinational opcode -> class/alu_op/illegal).
//  FSM register + next-state block + output block in this module.
// TESTING
//  ADD (op 1), mem_ready=1 -> states 0,1,2,4,0; alu_op=001 in EXEC; 1 reg_write.
//  LW with mem_ready low 3 cyc in MEM -> mem_read held 4 cyc, addr_src=1,
//   wb_src=1 in WB; total 8 cycles.
//  BEQ zero=1 -> pc_write=1 pc_src=1 in EXEC; zero=0 -> pc_write=0; both FETCH.
//  Opcode 10 -> HALT, illegal=1, all enables 0 for 20 cycles; reset -> FETCH.
//  reset asserted in MEM of SW -> no mem_write that cycle; FETCH next.
//  FETCH with mem_ready=0 5 cyc -> ir_write/pc_write stay 0 until ready.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle control unit, datapath and ALU
package mc_ctrl_pkg;
  localparam int OPC_W   = 4;
  localparam int ALUOP_W = 3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPC_W-1:0] OP_AND  = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'd3;
  localparam logic [OPC_W-1:0] OP_LW   = 4'd4;
  localparam logic [OPC_W-1:0] OP_SW   = 4'd5;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'd6;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'd7;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'd8;
  localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b010;

  localparam logic [1:0] PC_SRC_ALU = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] ALUB_REGB = 2'd0;
  localparam logic [1:0] ALUB_ONE  = 2'd1;
  localparam logic [1:0] ALUB_IMM  = 2'd2;

  typedef enum logic [3:0] {
    IC_RTYPE, IC_ADDI, IC_LW, IC_SW, IC_BEQ, IC_BNE, IC_JMP, IC_HALT, IC_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               addr_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               reg_write;
    logic               wb_src;
  } ctrl_t;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control bus between sequencer (master) and datapath (slave)
interface multicycle_control_unit_if;
  import mc_ctrl_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic               zero;
  logic               negative;
  logic               mem_ready;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               addr_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               reg_write;
  logic               wb_src;
  logic               illegal;
  logic [2:0]         state_o;
  logic               neg_q;

  modport master (
    input  opcode, zero, negative, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, addr_src,
           alu_op, alu_src_a, alu_src_b, reg_write, wb_src, illegal, state_o, neg_q
  );

  modport slave (
    output opcode, zero, negative, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, addr_src,
           alu_op, alu_src_a, alu_src_b, reg_write, wb_src, illegal, state_o, neg_q
  );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode classifier and R-type ALU select
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode,
  output iclass_t            iclass,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
);
  always_comb begin
    iclass  = IC_ILLEGAL;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_AND:  begin iclass = IC_RTYPE; alu_op = ALU_AND; end
      OP_ADD:  begin iclass = IC_RTYPE; alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = IC_RTYPE; alu_op = ALU_SUB; end
      OP_ADDI: iclass = IC_ADDI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  begin iclass = IC_BEQ; alu_op = ALU_SUB; end
      OP_BNE:  begin iclass = IC_BNE; alu_op = ALU_SUB; end
      OP_JMP:  iclass = IC_JMP;
      OP_HALT: iclass = IC_HALT;
      default: begin iclass = IC_ILLEGAL; illegal = 1'b1; end
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB sequencer of the 16-bit multicycle core
module multicycle_control_unit
  import mc_ctrl_pkg::*;
(
  input logic                        clk,
  input logic                        reset,
  multicycle_control_unit_if.master  bus
);
  state_t             state, state_next;
  logic               illegal_q, neg_q;
  iclass_t            iclass;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_illegal;
  ctrl_t              ctrl, ctrl_out;

  mc_decode u_decode (
    .opcode  (bus.opcode),
    .iclass  (iclass),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  // negative is captured for a future BLT; nothing consumes it yet
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE && dec_illegal) illegal_q <= 1'b1;
      if (state == S_EXEC) neg_q <= bus.negative;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = dec_illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (iclass)
          IC_RTYPE, IC_ADDI:      state_next = S_WB;
          IC_LW, IC_SW:           state_next = S_MEM;
          IC_BEQ, IC_BNE, IC_JMP: state_next = S_FETCH;
          default:                state_next = S_HALT;
        endcase
      end
      S_MEM:    if (bus.mem_ready) state_next = (iclass == IC_LW) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_ONE;
        ctrl.alu_op    = ALU_ADD;
        // IR and PC only load on the cycle memory actually returns the word
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_ALU;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        case (iclass)
          IC_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REGB;
            ctrl.alu_op    = dec_alu_op;
          end
          IC_ADDI, IC_LW, IC_SW: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          IC_BEQ, IC_BNE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REGB;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_SRC_BR;
            ctrl.pc_write  = (iclass == IC_BEQ) ? bus.zero : !bus.zero;
          end
          IC_JMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_JMP;
          end
          default: ctrl = '0;
        endcase
      end
      S_MEM: begin
        ctrl.addr_src  = 1'b1;
        ctrl.mem_read  = (iclass == IC_LW);
        ctrl.mem_write = (iclass == IC_SW);
      end
      S_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_src    = (iclass == IC_LW);
      end
      default: ctrl = '0;
    endcase
  end

  // reset silences every enable in the cycle it is sampled
  assign ctrl_out      = reset ? '0 : ctrl;
  assign bus.pc_write  = ctrl_out.pc_write;
  assign bus.pc_src    = ctrl_out.pc_src;
  assign bus.ir_write  = ctrl_out.ir_write;
  assign bus.mem_read  = ctrl_out.mem_read;
  assign bus.mem_write = ctrl_out.mem_write;
  assign bus.addr_src  = ctrl_out.addr_src;
  assign bus.alu_op    = ctrl_out.alu_op;
  assign bus.alu_src_a = ctrl_out.alu_src_a;
  assign bus.alu_src_b = ctrl_out.alu_src_b;
  assign bus.reg_write = ctrl_out.reg_write;
  assign bus.wb_src    = ctrl_out.wb_src;
  assign bus.illegal   = illegal_q & !reset;
  assign bus.neg_q     = neg_q & !reset;
  assign bus.state_o   = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - instruction-level expected-trace bench for the control unit
module tb_multicycle_control_unit;
  logic clk = 1'b1;
  logic reset;
  multicycle_control_unit_if bus();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    logic [3:0]  op;
    bit          z;
    bit          n;
    bit          mr;
    logic [19:0] exp;
  } vec_t;

  vec_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;
  bit   active = 1'b0;
  bit   m_ill = 1'b0;
  bit   m_neg = 1'b0;
  int   obs_regwrite = 0, obs_memwrite = 0, obs_lwread = 0, obs_taken = 0, obs_illegal = 0;

  task automatic push(input bit rst, input logic [3:0] op, input bit z, input bit mr,
                      input logic [2:0] st, input bit pw, input logic [1:0] ps, input bit irw,
                      input bit mrd, input bit mw, input bit as, input logic [2:0] aop,
                      input bit asa, input logic [1:0] asb, input bit rw, input bit ws);
    vec_t v;
    v.chk = (q.size() != 0);
    v.rst = rst;
    v.op  = op;
    v.z   = z;
    v.n   = (q.size() % 3) == 1;
    v.mr  = mr;
    if (rst) v.exp = {st, 17'b0};
    else     v.exp = {st, pw, ps, irw, mrd, mw, as, aop, asa, asb, rw, ws, m_ill, m_neg};
    q.push_back(v);
    if (rst) begin
      m_ill = 1'b0;
      m_neg = 1'b0;
    end else begin
      if (st == 3'd2) m_neg = v.n;
      if (st == 3'd1 && op >= 4'd9 && op <= 4'd14) m_ill = 1'b1;
    end
  endtask

  task automatic rst_cycle(input logic [2:0] st);
    push(1, 4'd0, 0, 1, st, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0);
  endtask

  task automatic halt_cycles(input logic [3:0] op, input int n);
    for (int i = 0; i < n; i++) push(0, op, 0, 1, 3'd5, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0);
  endtask

  // one instruction expanded into its expected cycle trace
  task automatic instr(input logic [3:0] op, input bit z, input int fst, input int mst, input bit rst_in_mem);
    for (int i = 0; i < fst; i++) push(0, op, 0, 0, 3'd0, 0, 2'd0, 0, 1, 0, 0, 3'b001, 0, 2'd1, 0, 0);
    push(0, op, 0, 1, 3'd0, 1, 2'd0, 1, 1, 0, 0, 3'b001, 0, 2'd1, 0, 0);
    push(0, op, 0, 1, 3'd1, 0, 2'd0, 0, 0, 0, 0, 3'b001, 0, 2'd2, 0, 0);
    if (op >= 4'd9 && op <= 4'd14) return;
    case (op)
      4'd0, 4'd1, 4'd2: begin
        push(0, op, z, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, op[2:0], 1, 2'd0, 0, 0);
        push(0, op, 0, 1, 3'd4, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 1, 0);
      end
      4'd3: begin
        push(0, op, z, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 3'b001, 1, 2'd2, 0, 0);
        push(0, op, 0, 1, 3'd4, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 1, 0);
      end
      4'd4, 4'd5: begin
        push(0, op, z, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 3'b001, 1, 2'd2, 0, 0);
        if (rst_in_mem) begin
          rst_cycle(3'd3);
          return;
        end
        for (int i = 0; i < mst; i++) push(0, op, 0, 0, 3'd3, 0, 2'd0, 0, op == 4'd4, op == 4'd5, 1, 3'd0, 0, 2'd0, 0, 0);
        push(0, op, 0, 1, 3'd3, 0, 2'd0, 0, op == 4'd4, op == 4'd5, 1, 3'd0, 0, 2'd0, 0, 0);
        if (op == 4'd4) push(0, op, 0, 1, 3'd4, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 1, 1);
      end
      4'd6: push(0, op, z, 1, 3'd2, z, 2'd1, 0, 0, 0, 0, 3'b010, 1, 2'd0, 0, 0);
      4'd7: push(0, op, z, 1, 3'd2, !z, 2'd1, 0, 0, 0, 0, 3'b010, 1, 2'd0, 0, 0);
      4'd8: push(0, op, z, 1, 3'd2, 1, 2'd2, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0);
      default: push(0, op, z, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0);
    endcase
  endtask

  task automatic lit(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (active && q[cur].chk) begin
      logic [19:0] got;
      got = {bus.state_o, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
             bus.addr_src, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.wb_src,
             bus.illegal, bus.neg_q};
      total++;
      if (got !== q[cur].exp) begin
        bad++;
        $display("FAIL cyc%0d op=%0d actual=%b required=%b", cur, q[cur].op, got, q[cur].exp);
      end
      if (bus.reg_write === 1'b1) obs_regwrite++;
      if (bus.mem_write === 1'b1) obs_memwrite++;
      if (bus.mem_read === 1'b1 && bus.addr_src === 1'b1) obs_lwread++;
      if (bus.pc_write === 1'b1 && bus.pc_src === 2'd1) obs_taken++;
      if (bus.illegal === 1'b1) obs_illegal++;
    end
  end

  initial begin
    push(1, 4'd0, 0, 1, 3'd0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0, 0);
    rst_cycle(3'd0);
    instr(4'd1, 0, 0, 0, 0);
    instr(4'd4, 0, 0, 3, 0);
    instr(4'd6, 1, 0, 0, 0);
    instr(4'd6, 0, 0, 0, 0);
    instr(4'd7, 0, 0, 0, 0);
    instr(4'd7, 1, 0, 0, 0);
    instr(4'd8, 0, 0, 0, 0);
    instr(4'd3, 1, 0, 0, 0);
    instr(4'd2, 0, 2, 0, 0);
    instr(4'd0, 0, 0, 0, 0);
    instr(4'd5, 0, 5, 1, 0);
    instr(4'd5, 0, 0, 0, 1);
    instr(4'd15, 0, 0, 0, 0);
    halt_cycles(4'd15, 3);
    rst_cycle(3'd5);
    instr(4'd10, 0, 0, 0, 0);
    halt_cycles(4'd10, 20);
    rst_cycle(3'd5);
    instr(4'd1, 0, 0, 0, 0);

    for (int i = 0; i < q.size(); i++) begin
      reset         = q[i].rst;
      bus.opcode    = q[i].op;
      bus.zero      = q[i].z;
      bus.negative  = q[i].n;
      bus.mem_ready = q[i].mr;
      cur           = i;
      active        = 1'b1;
      @(posedge clk);
      #1;
    end
    active = 1'b0;

    lit("reg_write_pulses", obs_regwrite, 6);
    lit("mem_write_cycles", obs_memwrite, 2);
    lit("lw_mem_read_cycles", obs_lwread, 4);
    lit("branches_taken", obs_taken, 2);
    lit("illegal_cycles", obs_illegal, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
